// File: rtl/uart_pw_pkg.sv
// Shared types and constants for the UART password-check stage.
package uart_pw_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    RESPOND = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_Y  = 8'h59;
  localparam logic [7:0] ASCII_N  = 8'h4E;

  localparam int ATT_W = 16;

endpackage : uart_pw_pkg

// File: rtl/uart_pw_check.sv
// Password-check stage between uart_rx and uart_tx: collects bytes up to a
// terminator, compares in constant time, and returns one verdict byte.
module uart_pw_check
  import uart_pw_pkg::*;
#(
  parameter int                    PW_LEN   = 4,
  parameter logic [8*PW_LEN-1:0]   PASSWORD = 32'h6877736C,
  parameter logic [7:0]            TERM     = ASCII_CR,
  parameter logic [7:0]            ACK_OK   = ASCII_Y,
  parameter logic [7:0]            ACK_FAIL = ASCII_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_rdy,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic             unlocked,
  output logic [ATT_W-1:0] attempts
);

  localparam int CNT_W = $clog2(PW_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PW_LEN);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mism_q, mism_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               unlocked_q, unlocked_d;
  logic [ATT_W-1:0]   attempts_q, attempts_d;

  logic [7:0]         exp_byte;
  logic               match;

  // Password byte at the current index; first byte is the most significant.
  always_comb begin
    exp_byte = '0;
    for (int i = 0; i < PW_LEN; i++) begin
      if (cnt_q == CNT_W'(i)) exp_byte = PASSWORD[8*(PW_LEN-1-i) +: 8];
    end
  end

  assign match = (cnt_q == CNT_FULL) && !mism_q && !ovf_q;
  assign tx_en = (state_q == RESPOND) && tx_rdy;

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mism_d     = mism_q;
    ovf_d      = ovf_q;
    tx_data_d  = tx_data_q;
    unlocked_d = unlocked_q;
    attempts_d = attempts_q;

    unique case (state_q)
      COLLECT: begin
        if (rx_valid) begin
          if (rx_data != TERM) begin
            // Every byte does the same work whether or not it matches.
            if (cnt_q != CNT_FULL) begin
              if (rx_data != exp_byte) mism_d = 1'b1;
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            tx_data_d = match ? ACK_OK : ACK_FAIL;
            if (match) unlocked_d = 1'b1;
            if (attempts_q != '1) attempts_d = attempts_q + ATT_W'(1);
            cnt_d   = '0;
            mism_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: begin
        if (tx_rdy) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather
  // than in the sensitivity list; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      mism_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      unlocked_q <= 1'b0;
      attempts_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mism_q     <= mism_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      unlocked_q <= unlocked_d;
      attempts_q <= attempts_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign unlocked = unlocked_q;
  assign attempts = attempts_q;

endmodule : uart_pw_check

// File: tb/tb_uart_pw_check.sv
// Self-checking bench for uart_pw_check: directed scenarios plus random
// attempts scored against a queue-based model of the password rules.
module tb_uart_pw_check;

  localparam int PW_LEN = 4;
  localparam logic [7:0] CR = 8'h0D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_rdy = 1'b1;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        unlocked;
  logic [15:0] attempts;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] pw[PW_LEN];
  logic [7:0] m_col[$];
  logic [7:0] stim[$];
  int         m_att = 0;
  logic       m_unl = 1'b0;
  logic [7:0] m_tx  = 8'h00;

  uart_pw_check dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_rdy   (tx_rdy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .unlocked (unlocked),
    .attempts (attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col.delete();
    m_att = 0;
    m_unl = 1'b0;
    m_tx  = 8'h00;
  endtask

  task automatic model_term();
    logic ok;
    ok = (m_col.size() == PW_LEN);
    if (ok) begin
      for (int i = 0; i < PW_LEN; i++) if (m_col[i] != pw[i]) ok = 1'b0;
    end
    m_tx  = ok ? 8'h59 : 8'h4E;
    m_unl = m_unl | ok;
    if (m_att < 65535) m_att++;
    m_col.delete();
  endtask

  // Drive one byte in COLLECT; called at a negedge, returns at the next one.
  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (b == CR) model_term();
    else         m_col.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic load_str(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == CR);
    return b;
  endfunction

  // Send stim then CR; verdict must be visible in the very next cycle.
  task automatic run_attempt(input string tag, input bit poke);
    foreach (stim[i]) drive_byte(stim[i]);
    drive_byte(CR);
    check({tag, ".tx_en"},    32'(tx_en),    32'h1);
    check({tag, ".tx_data"},  32'(tx_data),  32'(m_tx));
    check({tag, ".unlocked"}, 32'(unlocked), 32'(m_unl));
    check({tag, ".attempts"}, 32'(attempts), 32'(m_att));
    if (poke) begin
      rx_valid = 1'b1;
      rx_data  = "h";
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check({tag, ".tx_en_one"}, 32'(tx_en), 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".tx_en"},    32'(tx_en),    32'h0);
    check({tag, ".tx_data"},  32'(tx_data),  32'h0);
    check({tag, ".unlocked"}, 32'(unlocked), 32'h0);
    check({tag, ".attempts"}, 32'(attempts), 32'h0);
  endtask

  initial begin
    pw[0] = "h"; pw[1] = "w"; pw[2] = "s"; pw[3] = "l";

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // Correct password
    load_str("hwsl");  run_attempt("correct", 1'b0);

    // Wrong / short / long input, counted from a fresh reset
    rst = 1'b0; @(negedge clk); rst = 1'b1; model_reset();
    load_str("hwsm");  run_attempt("wrong_last", 1'b0);
    load_str("hws");   run_attempt("short", 1'b0);
    load_str("hwslx"); run_attempt("overflow", 1'b0);
    check("attempts_three", 32'(attempts), 32'd3);

    // Empty attempt and mismatch position independence
    load_str("");      run_attempt("empty", 1'b0);
    load_str("xwsl");  run_attempt("mism_b0", 1'b0);
    load_str("hwsx");  run_attempt("mism_b3", 1'b0);

    // Byte during handshake cycle is dropped, so "wsl" alone must fail
    load_str("hwsl");  run_attempt("unlock", 1'b1);
    load_str("wsl");   run_attempt("handshake_drop", 1'b0);
    check("sticky_unlock", 32'(unlocked), 32'h1);

    // Backpressure: verdict waits, bytes (including CR) are dropped
    tx_rdy = 1'b0;
    load_str("abc");
    foreach (stim[i]) drive_byte(stim[i]);
    drive_byte(CR);
    check("stall.tx_data",  32'(tx_data),  32'(m_tx));
    check("stall.attempts", 32'(attempts), 32'(m_att));
    for (int i = 0; i < 20; i++) begin
      check("stall.no_tx_en", 32'(tx_en), 32'h0);
      rx_valid = 1'b1;
      rx_data  = (i % 5 == 4) ? CR : rand_byte();
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check("stall.attempts_held", 32'(attempts), 32'(m_att));
    tx_rdy = 1'b1;
    #1;
    check("stall.release_en", 32'(tx_en), 32'h1);
    @(negedge clk);
    check("stall.release_one", 32'(tx_en), 32'h0);
    load_str("hwsl");  run_attempt("after_stall", 1'b0);

    // Random attempts against the model
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      stim.delete();
      case (kind)
        0: for (int i = 0; i < PW_LEN; i++) stim.push_back(pw[i]);
        1: begin
          for (int i = 0; i < PW_LEN; i++) stim.push_back(pw[i]);
          stim[$urandom_range(0, PW_LEN-1)] = rand_byte();
        end
        2: begin
          int len;
          len = int'($urandom_range(0, 6));
          for (int i = 0; i < len; i++) stim.push_back(rand_byte());
        end
        default: begin
          for (int i = 0; i < PW_LEN; i++) stim.push_back(pw[i]);
          stim.push_back(rand_byte());
        end
      endcase
      run_attempt("random", 1'b0);
    end

    // Reset mid-stream
    drive_byte("h"); drive_byte("w");
    rst = 1'b0; @(negedge clk); model_reset();
    check_zero("rst_mid_collect");
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_collect_rel");
    load_str("hwsl");  run_attempt("after_rst", 1'b0);

    // Reset while a verdict is pending
    tx_rdy = 1'b0;
    load_str("sl");
    foreach (stim[i]) drive_byte(stim[i]);
    drive_byte(CR);
    rst = 1'b0; @(negedge clk); model_reset();
    rst = 1'b1; tx_rdy = 1'b1;
    #1;
    check_zero("rst_mid_respond");
    @(negedge clk);
    check("rst_mid_respond.no_en", 32'(tx_en), 32'h0);
    load_str("hwsl");  run_attempt("after_rst2", 1'b0);

    // Saturation of the attempt counter
    force dut.attempts_q = 16'hFFFE;
    @(negedge clk);
    release dut.attempts_q;
    m_att = 65534;
    @(negedge clk);
    check("sat.preload", 32'(attempts), 32'hFFFE);
    load_str("x");     run_attempt("sat_reach", 1'b0);
    load_str("");      run_attempt("sat_hold", 1'b0);
    check("sat.final", 32'(attempts), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_pw_check

// File: doc/uart_pw_check.md
# uart_pw_check

Password-check stage between `uart_rx` and `uart_tx`, replacing direct echo glue in the brute-force target design. It does the following:
- Collects received bytes until a terminator byte arrives.
- Compares the collected bytes against a parameterised password in constant time.
- Hands one verdict byte to the transmitter through the existing `en`/`rdy` handshake.
- Keeps a sticky unlock flag and a saturating attempt counter for the lab host.

## Interface
Parameters:
- `PW_LEN`, 4: password length in bytes, range 1–32.
- `PASSWORD`, 32'h6877736C ("hwsl"): width 8*PW_LEN. First expected byte is `PASSWORD[8*PW_LEN-1 -: 8]`.
- `TERM`, 8'h0D: terminator byte. It is never compared and never counted.
- `ACK_OK`, 8'h59 ('Y'): verdict sent on a match.
- `ACK_FAIL`, 8'h4E ('N'): verdict sent on a mismatch.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-low.
- `rst` in 1: synchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe from `uart_rx`; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `tx_rdy` in 1: transmitter idle.
- `tx_en` out 1: transmit strobe. `tx_data` is captured by `uart_tx` when `tx_en` is high.
- `tx_data` out 8: verdict byte.
- `unlocked` out 1: sticky high after the first successful match.
- `attempts` out 16: count of terminators received, saturating at 16'hFFFF.

## Operation
- States: COLLECT (reset state) and RESPOND.
- COLLECT, `rx_valid` with `rx_data != TERM`:
  - Byte index is `cnt`, width $clog2(PW_LEN+1), saturating at PW_LEN.
  - If `cnt < PW_LEN`: compare against the password byte at `cnt`; set the sticky `mism` flag on a difference; then `cnt++`.
  - If `cnt == PW_LEN`: set `ovf`. The byte is otherwise ignored.
- COLLECT, `rx_valid` with `rx_data == TERM`:
  - Match iff `cnt == PW_LEN && !mism && !ovf`.
  - `tx_data` <= ACK_OK on a match, else ACK_FAIL.
  - On a match, `unlocked` <= 1.
  - `attempts` increments, saturating.
  - `cnt`, `mism` and `ovf` clear.
  - Go to RESPOND.
- Comparison is constant-time: there is no early exit or early response on mismatch. The response cycle depends only on terminator arrival and `tx_rdy`.
- RESPOND:
  - `tx_en = (state == RESPOND) & tx_rdy`, combinational, the same rule as the `en = rdy & valid` glue.
  - In the cycle `tx_en` is high, the next state is COLLECT.
- `rx_valid` while in RESPOND, including the handshake cycle itself, is dropped with no side effects.
- A terminator with `cnt == 0` counts as an attempt and returns ACK_FAIL. This rule holds even if the password length would otherwise match.
- `unlocked` clears only on reset.

## Timing
- Reset (`rst == 0` at a rising edge) clears the block regardless of state:
  - state = COLLECT;
  - `cnt`, `mism`, `ovf` = 0;
  - `tx_data` = 8'h00, `tx_en` = 0, `unlocked` = 0, `attempts` = 0.
- Reset mid-collect or mid-RESPOND discards the pending verdict. No `tx_en` is issued.
- Terminator strobe at cycle t:
  - RESPOND holds from t+1.
  - Earliest `tx_en` is t+1, if `tx_rdy` is high.
  - `tx_data`, `unlocked` and `attempts` update at t+1.
- `tx_en` is high for exactly one cycle per terminator. `tx_data` is stable throughout RESPOND.
- If `tx_rdy` is low, RESPOND holds indefinitely.
- Back-to-back bytes at consecutive cycles in COLLECT are all accepted. There is no bubble.

## Structure
- Package `uart_pw_pkg`: state enum (COLLECT, RESPOND), ASCII constants for CR, 'Y' and 'N', and the `ATT_W = 16` width constant.
- No sub-module. The byte select is an indexed part-select of `PASSWORD`.
- Top-level integration instantiates `uart_rx` → `uart_pw_check` → `uart_tx`, all sharing `SYSTEM_CLOCK` and `BAUD_RATE`.

## Test plan
All scenarios use default parameters and assume `tx_rdy = 1` unless stated.
- Correct password: "hwsl" then 0x0D → `tx_en` one cycle at t+1 with `tx_data` = 0x59; `unlocked` = 1; `attempts` = 1.
- Wrong last byte and short input:
  - "hwsm" then CR → 0x4E at t+1, `unlocked` stays 0.
  - "hws" then CR → 0x4E.
  - "hwslx" then CR → 0x4E (ovf).
  - `attempts` = 3 after these three.
- Mismatch position independence: mismatch at byte 0 ("xwsl") and at byte 3 ("hwsx") → `tx_en` in the same cycle offset from CR (t+1) for both.
- Backpressure: CR with `tx_rdy = 0` for 20 cycles → no `tx_en`. Bytes sent during the stall are dropped. Then `tx_rdy = 1` → a single `tx_en`, and the next "hwsl"+CR → 0x59.
- Reset and stickiness:
  - Unlock, then wrong attempt → `unlocked` remains 1.
  - Assert `rst = 0` mid-byte-stream → all outputs zero, no verdict sent. After release, "hwsl"+CR → 0x59.
  - Force `attempts` to 16'hFFFF → one more CR keeps it at 16'hFFFF.
